mux_sel_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the 4-to-1 mux and drives the mux select lines s1 and s0.
- Four sources raise requests. The block grants one source at a time, holds the grant for a bounded number of cycles, then rotates priority.
- Select outputs connect straight to the mux select ports. The valid flag tells the consumer when the mux output carries a granted source.

---
 rtl/mux_sel_pkg.sv | 35 +++
 rtl/rr_pick_4.sv | 19 +
 rtl/mux_sel_arbiter.sv | 112 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared types and the round-robin pick function for the 4-to-1 mux select arbiter.
// The pick searches ptr, ptr+1, ... modulo 4 and reports the first requesting channel.
package mux_sel_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [1:0] sel_t;

  typedef struct packed {
    logic found;
    sel_t idx;
  } pick_t;

  // Walks the offsets from highest to lowest so the smallest offset from ptr
  // is the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req, input sel_t ptr);
    pick_t res;
    sel_t  cand;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = ptr + sel_t'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotate-and-priority-encode over four requesters.
module rr_pick_4
  import mux_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic              found,
  output sel_t              idx
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(req, ptr);
    found = pick.found;
    idx   = pick.idx;
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select lines of a 4-to-1 mux.
// Grants are held for at most MAX_HOLD cycles; all outputs are registered.
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int NUM_CH   = mux_sel_pkg::NUM_CH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic [7:0] hold_cnt
);

  if (NUM_CH != 4) begin : g_bad_num_ch
    $error("mux_sel_arbiter: NUM_CH must be 4");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_sel_arbiter: MAX_HOLD must be in 1..255");
  end

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  sel_t       ptr_q, ptr_d;
  sel_t       sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic [7:0] hold_q, hold_d;

  sel_t pick_ptr;
  sel_t pick_idx;
  logic pick_found;
  logic rel;

  rr_pick_4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    pick_ptr = ptr_q;
    rel      = 1'b0;

    // On release the pointer advances past the current owner and the new
    // pointer is used for arbitration in the same cycle, so there is no bubble.
    if (state_q == GRANT) begin
      rel = !req[sel_q] || (hold_q == HOLD_LAST);
      if (rel) begin
        pick_ptr = sel_q + 2'd1;
      end
    end

    if (state_q == IDLE || rel) begin
      if (rel) begin
        ptr_d = pick_ptr;
      end
      if (pick_found) begin
        state_d = GRANT;
        gnt_d   = 4'b0001 << pick_idx;
        sel_d   = pick_idx;
        valid_d = 1'b1;
        hold_d  = 8'd0;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        sel_d   = 2'd0;
        valid_d = 1'b0;
        hold_d  = 8'd0;
      end
    end else begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt      = gnt_q;
  assign s1       = sel_q[1];
  assign s0       = sel_q[0];
  assign valid    = valid_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1) share stimulus
// and are checked every cycle against an integer-level round-robin model.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt4, gnt1;
  logic       s1_4, s0_4, valid4, s1_1, s0_1, valid1;
  logic [7:0] hold4, hold1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Index 0 models the MAX_HOLD=4 instance, index 1 the MAX_HOLD=1 instance.
  int m_cur[2] = '{-1, -1};
  int m_ptr[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  int m_max[2] = '{4, 1};

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt4),
    .s1(s1_4), .s0(s0_4), .valid(valid4), .hold_cnt(hold4)
  );

  mux_sel_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt1),
    .s1(s1_1), .s0(s0_1), .valid(valid1), .hold_cnt(hold1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a grant ends when its request drops or its time slice is used up;
  // the next owner is the first requester found starting just after the old owner.
  task automatic model_step(input int k);
    bit rel;
    int w;
    if (m_cur[k] < 0) rel = 1'b1;
    else rel = (req[m_cur[k]] == 1'b0) || (m_cnt[k] == m_max[k] - 1);
    if (rel) begin
      if (m_cur[k] >= 0) m_ptr[k] = (m_cur[k] + 1) % 4;
      w = -1;
      for (int j = 0; j < 4; j++) begin
        if (w < 0 && req[(m_ptr[k] + j) % 4]) w = (m_ptr[k] + j) % 4;
      end
      m_cur[k] = w;
      m_cnt[k] = 0;
    end else begin
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_cur[k] = -1;
        m_ptr[k] = 0;
        m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic check_dut(input int k, input logic [3:0] g, input logic [1:0] sel,
                           input logic v, input logic [7:0] h);
    logic [3:0] eg;
    string tag;
    tag = $sformatf("mh%0d", m_max[k]);
    eg  = (m_cur[k] < 0) ? 4'b0000 : 4'(1 << m_cur[k]);
    chk({tag, " gnt"}, 32'(g), 32'(eg));
    chk({tag, " sel"}, 32'(sel), (m_cur[k] < 0) ? 32'd0 : 32'(m_cur[k]));
    chk({tag, " valid"}, 32'(v), (m_cur[k] < 0) ? 32'd0 : 32'd1);
    chk({tag, " hold_cnt"}, 32'(h), 32'(m_cnt[k]));
    chk({tag, " onehot0"}, 32'($onehot0(g)), 32'd1);
    chk({tag, " valid_vs_gnt"}, 32'(v), 32'(|g));
    if (v) chk({tag, " sel_vs_gnt"}, 32'(4'(4'b0001 << sel)), 32'(g));
    chk({tag, " hold_range"}, 32'(h < 8'(m_max[k])), 32'd1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, gnt4, {s1_4, s0_4}, valid4, hold4);
      check_dut(1, gnt1, {s1_1, s0_1}, valid1, hold1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1;
    req = 4'b0000;
    repeat (3) tick();
    chk("reset gnt4", 32'(gnt4), 32'd0);
    chk("reset sel4", 32'({s1_4, s0_4}), 32'd0);
    chk("reset valid4", 32'(valid4), 32'd0);
    chk("reset hold4", 32'(hold4), 32'd0);
    chk("reset gnt1", 32'(gnt1), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single requester, then drop: one-cycle latency each way.
    do_reset();
    req = 4'b0001;
    tick();
    chk("single gnt", 32'(gnt4), 32'h1);
    chk("single sel", 32'({s1_4, s0_4}), 32'd0);
    chk("single valid", 32'(valid4), 32'd1);
    req = 4'b0000;
    tick();
    chk("drop gnt", 32'(gnt4), 32'h0);
    chk("drop valid", 32'(valid4), 32'd0);

    // All requesting: slices of four for MAX_HOLD=4, rotate every cycle for MAX_HOLD=1.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      tick();
      e = 4'(1 << ((i / 4) % 4));
      chk("all gnt4", 32'(gnt4), 32'(e));
      chk("all hold4", 32'(hold4), 32'(i % 4));
      chk("all valid4", 32'(valid4), 32'd1);
      e = 4'(1 << (i % 4));
      chk("all gnt1", 32'(gnt1), 32'(e));
    end

    // Lone requester re-wins with no bubble; only the counter restarts.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("lone gnt4", 32'(gnt4), 32'h4);
      chk("lone sel4", 32'({s1_4, s0_4}), 32'd2);
      chk("lone hold4", 32'(hold4), 32'(i % 4));
    end

    // Pointer wraps from channel 3 back to channel 0.
    do_reset();
    req = 4'b1000;
    tick();
    chk("wrap gnt3", 32'(gnt4), 32'h8);
    req = 4'b1001;
    tick();
    chk("wrap hold", 32'(gnt4), 32'h8);
    req = 4'b0001;
    tick();
    chk("wrap gnt0", 32'(gnt4), 32'h1);
    chk("wrap sel0", 32'({s1_4, s0_4}), 32'd0);

    // MAX_HOLD=1 with two requesters alternates every cycle.
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("alt gnt1", 32'(gnt1), (i % 2 == 0) ? 32'h2 : 32'h8);
    end

    // Asynchronous reset in the middle of a channel-2 grant.
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    chk("mid gnt before rst", 32'(gnt4), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("mid rst gnt", 32'(gnt4), 32'h0);
    chk("mid rst sel", 32'({s1_4, s0_4}), 32'd0);
    chk("mid rst valid", 32'(valid4), 32'd0);
    chk("mid rst hold", 32'(hold4), 32'd0);
    #2;
    rst = 1'b0;
    req = 4'b0010;
    tick();
    chk("after rst gnt", 32'(gnt4), 32'h2);
    chk("after rst sel", 32'({s1_4, s0_4}), 32'd1);

    // Random traffic with sticky requests and occasional reset pulses.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      tick();
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
